// File: rtl/font_text_reader.sv
// Character-cell text pixel generator: text RAM lookup -> font_ROM lookup -> serialised colour.
// Optional blinking cursor cell (FG/BG swap) when FONT_CURSOR_EN is defined.
module font_text_reader #(
    parameter int                H_CHARS  = 80,
    parameter int                V_CHARS  = 30,
    parameter int                RGB_W    = 12,
    parameter logic [RGB_W-1:0]  FG_COLOR = 12'hFFF,
    parameter logic [RGB_W-1:0]  BG_COLOR = 12'h000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             video_on,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
`ifdef FONT_CURSOR_EN
    input  logic [6:0]       cursor_col,
    input  logic [4:0]       cursor_row,
`endif
    output logic [11:0]      tile_addr,
    input  logic [6:0]       char_code,
    output logic [10:0]      rom_addr,
    input  logic [7:0]       rom_data,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync_out,
    output logic             vsync_out
);

    logic [6:0] col;
    logic [5:0] row;
    logic [3:0] glyph_row;
    logic [2:0] bit_sel;
    logic       in_text;

    assign col       = pixel_x[9:3];
    assign row       = pixel_y[9:4];
    assign glyph_row = pixel_y[3:0];
    assign bit_sel   = pixel_x[2:0];
    assign in_text   = (int'(col) < H_CHARS) && (int'(row) < V_CHARS);

    // Side-band shift registers; index 0 is stage 1, index 3 is stage 4.
    logic [3:0][2:0] bs_sr;
    logic [3:0]      act_sr;
    logic [3:0]      hs_sr;
    logic [3:0]      vs_sr;
    logic [3:0]      gr_s1;
    logic [3:0]      gr_s2;
    logic            cursor_inv;
    logic            pix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_addr <= '0;
            rom_addr  <= '0;
            bs_sr     <= '0;
            act_sr    <= '0;
            hs_sr     <= '1;
            vs_sr     <= '1;
            gr_s1     <= '0;
            gr_s2     <= '0;
        end else begin
            tile_addr <= 12'(int'(row) * H_CHARS + int'(col));
            rom_addr  <= {char_code, gr_s2};
            bs_sr     <= {bs_sr[2:0], bit_sel};
            act_sr    <= {act_sr[2:0], video_on & in_text};
            hs_sr     <= {hs_sr[2:0], hsync_in};
            vs_sr     <= {vs_sr[2:0], vsync_in};
            gr_s1     <= glyph_row;
            gr_s2     <= gr_s1;
        end
    end

`ifdef FONT_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       vs_prev;
    logic [3:0] cur_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b1;
            cur_sr    <= '0;
        end else begin
            if (vs_prev && !vsync_in)
                frame_cnt <= frame_cnt + 6'd1;
            vs_prev <= vsync_in;
            cur_sr  <= {cur_sr[2:0],
                        frame_cnt[5] && (col == cursor_col) && (row == {1'b0, cursor_row})};
        end
    end

    assign cursor_inv = cur_sr[3];
`else
    assign cursor_inv = 1'b0;
`endif

    // ~bit_sel == 7 - bit_sel: MSB of the glyph row is the leftmost pixel.
    always_comb begin
        pix = rom_data[~bs_sr[3]] ^ cursor_inv;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= act_sr[3] ? (pix ? FG_COLOR : BG_COLOR) : '0;
            hsync_out <= hs_sr[3];
            vsync_out <= vs_sr[3];
        end
    end

endmodule

// File: tb/tb_font_text_reader.sv
// Bench for font_text_reader: table vectors, hand sequences and random pixels against a cell-level model.
module tb_font_text_reader;
    localparam int          H_CHARS = 80;
    localparam int          V_CHARS = 30;
    localparam logic [11:0] FG      = 12'hFFF;
    localparam logic [11:0] BG      = 12'h000;
    localparam int          MAXC    = 4096;

    logic        clk = 1'b0;
    logic        rst_n, video_on, hsync_in, vsync_in;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] tile_addr;
    logic [6:0]  char_code = '0;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;
`ifdef FONT_CURSOR_EN
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
`endif

    always #5 clk = ~clk;

    font_text_reader #(
        .H_CHARS(H_CHARS), .V_CHARS(V_CHARS), .RGB_W(12), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
`ifdef FONT_CURSOR_EN
        .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
        .tile_addr(tile_addr), .char_code(char_code), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Text RAM and font ROM models; force_ff is delayed so it lands on the same pixel's ROM read.
    logic [6:0] text_ram [0:4095];
    logic [7:0] font_rom [0:2047];
    logic force_ff = 1'b0, frc_d1 = 1'b0, frc_d2 = 1'b0, frc_d3 = 1'b0;

    always @(posedge clk) begin
        char_code <= text_ram[tile_addr];
        rom_data  <= frc_d3 ? 8'hFF : font_rom[rom_addr];
        frc_d1    <= force_ff;
        frc_d2    <= frc_d1;
        frc_d3    <= frc_d2;
    end

    logic        h_rst [MAXC];
    logic [11:0] h_rgb [MAXC];
    logic        h_hs  [MAXC];
    logic        h_vs  [MAXC];
    logic [11:0] h_tile[MAXC];
    logic [10:0] h_rom [MAXC];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_falls = 0;
    logic        m_prev_vs = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic window_ok(input int a, input int b);
        for (int i = a; i <= b; i++)
            if (!h_rst[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One pixel clock: drive inputs, record model expectations, then check what is due at this edge.
    task automatic step(input logic rs, input logic vo, input logic hs, input logic vs, input logic frc,
                        input int x, input int y, input logic use_tab,
                        input logic [11:0] t_rgb, input logic t_hs, input logic t_vs);
        int col, row, gr, bs, taddr, k;
        logic act, pix, ok;
        logic [7:0] glyph;
        logic [6:0] ch;
        logic [10:0] romad;
        rst_n = rs; video_on = vo; hsync_in = hs; vsync_in = vs; force_ff = frc;
        pixel_x = 10'(x); pixel_y = 10'(y);
        col = x / 8; row = y / 16; gr = y % 16; bs = x % 8;
        act   = vo && (col < H_CHARS) && (row < V_CHARS);
        taddr = (row * H_CHARS + col) % 4096;
        ch    = text_ram[taddr];
        romad = {ch, 4'(gr)};
        glyph = frc ? 8'hFF : font_rom[romad];
        pix   = glyph[7 - bs];
`ifdef FONT_CURSOR_EN
        if (((m_falls / 32) % 2 == 1) && col == int'(cursor_col) && row == int'(cursor_row))
            pix = !pix;
        if (!rs) begin
            m_falls = 0; m_prev_vs = 1'b1;
        end else begin
            if (m_prev_vs && !vs) m_falls++;
            m_prev_vs = vs;
        end
`endif
        h_rst[cyc]  = rs;
        h_tile[cyc] = 12'(taddr);
        h_rom[cyc]  = romad;
        h_rgb[cyc]  = use_tab ? t_rgb : (act ? (pix ? FG : BG) : 12'h000);
        h_hs[cyc]   = use_tab ? t_hs : hs;
        h_vs[cyc]   = use_tab ? t_vs : vs;
        @(negedge clk);
        if (h_rst[cyc]) check("tile_addr", 32'(tile_addr), 32'(h_tile[cyc]));
        if (cyc >= 2 && window_ok(cyc - 2, cyc)) check("rom_addr", 32'(rom_addr), 32'(h_rom[cyc - 2]));
        if (cyc >= 4) begin
            k  = cyc - 4;
            ok = window_ok(k, cyc);
            check("rgb", 32'(rgb), 32'(ok ? h_rgb[k] : 12'h000));
            check("hsync_out", 32'(hsync_out), 32'(ok ? h_hs[k] : 1'b1));
            check("vsync_out", 32'(vsync_out), 32'(ok ? h_vs[k] : 1'b1));
        end
        cyc++;
    endtask

    typedef struct {
        int x; int y; logic vo; logic hs; logic vs; logic frc;
        logic [11:0] rgb; logic hso; logic vso;
    } vec_t;
    vec_t tab [14];

    initial begin
        logic rs, vo, hs, vs, frc;
        int x, y;
        for (int i = 0; i < 4096; i++) text_ram[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
        text_ram[162]     = 7'h41;
        font_rom[11'h413] = 8'h18;
`ifdef FONT_CURSOR_EN
        cursor_col = 7'd2;
        cursor_row = 5'd2;
`endif
        tab[0]  = '{17,  35,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
        tab[1]  = '{19,  35,  1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1};
        tab[2]  = '{20,  35,  1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1};
        tab[3]  = '{21,  35,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
        tab[4]  = '{19,  35,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
        tab[5]  = '{19,  35,  1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
        tab[6]  = '{17,  35,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
        tab[7]  = '{700, 35,  1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
        tab[8]  = '{639, 35,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
        tab[9]  = '{17,  479, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
        tab[10] = '{17,  480, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
        tab[11] = '{19,  35,  1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b1};
        tab[12] = '{19,  35,  1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0};
        tab[13] = '{400, 35,  1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};

        rst_n = 1'b0; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
        pixel_x = '0; pixel_y = '0;
        @(negedge clk);

        // Reset held for three edges with hsync_in low and video_on high.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17, 35, 1'b0, 12'h0, 1'b1, 1'b1);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_hsync", 32'(hsync_out), 32'h1);
        check("reset_vsync", 32'(vsync_out), 32'h1);
        check("reset_tile_addr", 32'(tile_addr), 32'h0);
        check("reset_rom_addr", 32'(rom_addr), 32'h0);

        foreach (tab[i])
            step(1'b1, tab[i].vo, tab[i].hs, tab[i].vs, tab[i].frc, tab[i].x, tab[i].y,
                 1'b1, tab[i].rgb, tab[i].hso, tab[i].vso);

        // Single-cycle hsync pulse must reach hsync_out exactly five edges later.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, (i == 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, 8 + i, 33, 1'b0, 12'h0, 1'b1, 1'b1);
            if (i == 5) check("align_before", 32'(hsync_out), 32'h1);
            if (i == 6) check("align_pulse", 32'(hsync_out), 32'h0);
            if (i == 7) check("align_after", 32'(hsync_out), 32'h1);
        end

        // Reset asserted in the middle of a continuous pixel stream.
        for (int i = 0; i < 12; i++) begin
            rs = !(i == 5 || i == 6);
            step(rs, 1'b1, 1'b1, 1'b1, 1'b1, 16 + i, 34, 1'b0, 12'h0, 1'b1, 1'b1);
            if (i == 5) begin
                check("midrst_rgb", 32'(rgb), 32'h0);
                check("midrst_hsync", 32'(hsync_out), 32'h1);
            end
        end

        for (int i = 0; i < 2000; i++) begin
            rs  = ($urandom_range(0, 199) != 0);
            vo  = ($urandom_range(0, 9) != 0);
            hs  = ($urandom_range(0, 9) != 0);
            vs  = ($urandom_range(0, 3) != 0);
            frc = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(8, 23);
                y = $urandom_range(32, 47);
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 599);
            end
            step(rs, vo, hs, vs, frc, x, y, 1'b0, 12'h0, 1'b1, 1'b1);
        end

        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19, 35, 1'b0, 12'h0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/font_text_reader.md
Name: font_text_reader

Overview:
- Character-cell text pixel generator for the VGA controller; it is the reader and consumer of font_ROM.
- It takes pixel coordinates and sync from the VGA sync generator and looks up the character code in a synchronous text RAM.
- It then addresses font_ROM (8x16 glyphs, 11-bit address, 8-bit row data, 1-cycle synchronous read) and serialises the returned row into colour pixels.
- Sync signals are delayed so they stay aligned with the colour output.

Parameters:
- H_CHARS, 80, character columns (8-px cells)
- V_CHARS, 30, character rows (16-px cells)
- RGB_W, 12, colour output width
- FG_COLOR, 12'hFFF, foreground colour (glyph bit = 1)
- BG_COLOR, 12'h000, background colour (glyph bit = 0)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- video_on  in  1  visible-area flag from sync generator
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- tile_addr  out  12  text RAM address, = row*H_CHARS + col
- char_code  in  7  text RAM read data, valid 1 cycle after tile_addr
- rom_addr  out  11  font_ROM address {char_code, glyph row}
- rom_data  in  8  font_ROM data, valid 1 cycle after rom_addr
- rgb  out  RGB_W  pixel colour
- hsync_out  out  1  hsync delayed to match rgb
- vsync_out  out  1  vsync delayed to match rgb

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Reset values:
  - tile_addr=0, rom_addr=0, rgb=0
  - hsync_out=1, vsync_out=1
  - all pipeline valid/shadow registers cleared
- Decode: col=pixel_x[9:3], row=pixel_y[9:4], glyph_row=pixel_y[3:0], bit_sel=pixel_x[2:0].
- in_text = (col < H_CHARS) && (row < V_CHARS).
- Pipeline, edges numbered from the cycle the pixel inputs are presented (E1 = first edge):
  - E1: tile_addr <= row*H_CHARS+col (constant multiply; 12-bit result; truncation impossible for defaults). Capture glyph_row, bit_sel, video_on&in_text, hsync_in, vsync_in into stage 1.
  - E2: text RAM clocks; char_code is valid after E2. Shift stage 1 to stage 2.
  - E3: rom_addr <= {char_code, glyph_row from stage 2}. Shift to stage 3.
  - E4: font_ROM clocks; rom_data is valid after E4. Shift to stage 4.
  - E5: rgb <= active ? (rom_data[7-bit_sel] ? FG_COLOR : BG_COLOR) : 0. Also hsync_out/vsync_out <= stage-4 sync values.
- Latency: exactly 5 clocks from inputs to rgb/hsync_out/vsync_out. Throughput 1 pixel/clock, no stalls.
- Bit order: MSB of rom_data is the leftmost pixel of the cell.
- active=0 (video_on low or outside text area) forces rgb=0 regardless of rom_data.
- tile_addr and rom_addr keep updating during blanking; their values are don't-care to the result.
- Reset mid-frame: all stages flush on the same edge. After rst_n returns high, the first valid rgb appears 5 edges later. Between those points rgb=0 and syncs=1.
- Wrap-around: pixel_x/pixel_y wrap handled by the sync generator; the block holds no frame state (except the optional feature).

Optional Feature:
- Macro: FONT_CURSOR_EN.
- Defined:
  - Adds inputs cursor_col[6:0] and cursor_row[4:0].
  - Adds a 6-bit frame counter, incremented on each vsync_in falling edge, cleared by reset.
  - Blink phase = counter[5], i.e. toggles every 32 frames.
  - When blink phase=1 and (col,row) match the cursor, FG/BG are swapped for that cell. The match is pipelined with the same 5-cycle alignment.
- Not defined: no cursor ports, no counter; behaviour exactly as above.

Test Plan:
- Reset: rst_n=0 for 3 edges while driving hsync_in=0, video_on=1 -> rgb=0, hsync_out=vsync_out=1, tile_addr=0, rom_addr=0.
- Lookup: pixel_x=17, pixel_y=35, video_on=1, model text RAM returns 7'h41 -> tile_addr=162 after E1, rom_addr=11'h413 after E3. Model ROM returns 8'h18, so rgb=FG_COLOR after E5 (bit_sel=1 -> bit6=0 gives BG; use pixel_x=19 -> bit4=1 -> FG).
- Alignment: single-cycle hsync_in=0 pulse with pixel stream -> hsync_out=0 exactly 5 edges later, coincident with that pixel's rgb.
- Blanking: video_on=0, rom_data forced 8'hFF -> rgb=0.
- Out of area: H_CHARS=40, pixel_x=400, video_on=1 -> rgb=0.
- Reset mid-stream: assert rst_n during continuous pixels -> rgb=0 next edge; first valid pixel 5 edges after release. With FONT_CURSOR_EN, the cursor cell inverts after 32 vsync falls.
